// File: rtl/store_write_buffer.sv
// Store write buffer: FIFO of word-aligned stores drained to data memory by req/ack, with load-hit detection and flush.
// Optional store merging into the youngest entry is enabled by defining WBUF_MERGE_EN.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_wdata,
  input  logic [3:0]        st_byteen,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  input  logic              flush,
  output logic              flush_done,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byteen
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSHING = 2'd1,
    DONE     = 2'd2
  } flushStateE;

  logic [WA_W-1:0]  entAddrR [DEPTH];
  logic [31:0]      entDataR [DEPTH];
  logic [3:0]       entBenR  [DEPTH];
  logic [DEPTH-1:0] entValidR;
  logic [PTR_W-1:0] headR;
  logic [PTR_W-1:0] tailR;
  logic [PTR_W:0]   countR;
  logic [PTR_W:0]   countNextS;
  logic             memReqR;
  flushStateE       stateR;

  logic [WA_W-1:0]  stWordS;
  logic [WA_W-1:0]  ldWordS;
  logic             mergeHitS;
  logic             stReadyS;
  logic             pushS;
  logic             allocS;
  logic             popS;
  logic             ldHitS;
  logic             unusedAddrBits;

  assign stWordS        = st_addr[ADDR_W-1:2];
  assign ldWordS        = ld_addr[ADDR_W-1:2];
  assign unusedAddrBits = ^{st_addr[1:0], ld_addr[1:0]};

`ifdef WBUF_MERGE_EN
  localparam logic [PTR_W:0] CNT_TWO = (PTR_W+1)'(2);
  logic [PTR_W-1:0] youngS;
  logic             mergeS;
  assign youngS    = tailR - PTR_ONE;
  // With two or more entries the youngest can never be the head under issue, so merging is safe.
  assign mergeHitS = (countR >= CNT_TWO) && (entAddrR[youngS] == stWordS);
  assign mergeS    = pushS && (st_byteen != 4'b0000) && mergeHitS;
`else
  assign mergeHitS = 1'b0;
`endif

  assign stReadyS = (stateR != FLUSHING) && ((countR < CNT_FULL) || mergeHitS);
  assign pushS    = st_valid && stReadyS;
  assign allocS   = pushS && (st_byteen != 4'b0000) && !mergeHitS;
  assign popS     = memReqR && mem_ack;

  // Occupancy update for the push/pop combinations.
  always_comb begin
    countNextS = countR;
    case ({allocS, popS})
      2'b10:   countNextS = countR + CNT_ONE;
      2'b01:   countNextS = countR - CNT_ONE;
      default: countNextS = countR;
    endcase
  end

  // Load hazard: compare load word address against every valid entry, head included.
  always_comb begin
    ldHitS = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ldHitS = ldHitS | (entValidR[i] && (entAddrR[i] == ldWordS));
    end
  end

  // Pointers, occupancy, valid bits and the registered memory request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headR     <= '0;
      tailR     <= '0;
      countR    <= '0;
      entValidR <= '0;
      memReqR   <= 1'b0;
    end else begin
      countR  <= countNextS;
      memReqR <= (countNextS != '0);
      if (allocS) begin
        tailR            <= tailR + PTR_ONE;
        entValidR[tailR] <= 1'b1;
      end
      if (popS) begin
        headR            <= headR + PTR_ONE;
        entValidR[headR] <= 1'b0;
      end
    end
  end

  // Entry payload storage; contents are qualified by the valid bits so no reset is needed.
  always_ff @(posedge clk) begin
    if (allocS) begin
      entAddrR[tailR] <= stWordS;
      entDataR[tailR] <= st_wdata;
      entBenR[tailR]  <= st_byteen;
    end
`ifdef WBUF_MERGE_EN
    else if (mergeS) begin
      entBenR[youngS] <= entBenR[youngS] | st_byteen;
      for (int b = 0; b < 4; b++) begin
        if (st_byteen[b]) begin
          entDataR[youngS][8*b +: 8] <= st_wdata[8*b +: 8];
        end
      end
    end
`endif
  end

  // Flush sequencing: block stores, drain, then pulse done for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR <= IDLE;
    end else begin
      case (stateR)
        IDLE: begin
          if (flush) begin
            stateR <= FLUSHING;
          end
        end
        FLUSHING: begin
          if ((countR == '0) || ((countR == CNT_ONE) && popS)) begin
            stateR <= DONE;
          end
        end
        DONE:    stateR <= IDLE;
        default: stateR <= IDLE;
      endcase
    end
  end

  assign st_ready   = stReadyS;
  assign ld_hit     = ld_valid && ldHitS;
  assign flush_done = (stateR == DONE);
  assign mem_req    = memReqR;
  assign mem_addr   = {entAddrR[headR], 2'b00};
  assign mem_wdata  = entDataR[headR];
  assign mem_byteen = entBenR[headR];

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: accepted stores are queued and matched against memory writes in order.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_wdata = 32'h0;
  logic [3:0]  st_byteen = 4'h0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic        ld_hit;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ben;
  } wrT;

  wrT sbQ[$];
  int checks = 0;
  int failures = 0;

  store_write_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_byteen(st_byteen),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .flush(flush), .flush_done(flush_done),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory-side monitor: pops the scoreboard on each handshake and checks head stability while stalled.
  logic        holdValid = 1'b0;
  logic [31:0] holdAddr, holdData;
  logic [3:0]  holdBen;
  always @(negedge clk) begin
    if (reset) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        checkEq("hold_req", mem_req, 1);
        checkEq("hold_addr", mem_addr, holdAddr);
        checkEq("hold_data", mem_wdata, holdData);
        checkEq("hold_ben", mem_byteen, holdBen);
      end
      if (mem_req && mem_ack) begin
        if (sbQ.size() == 0) begin
          checkEq("unexpected_write", mem_addr, 64'hDEAD);
        end else begin
          wrT e;
          e = sbQ.pop_front();
          checkEq("wr_addr", mem_addr, e.addr);
          checkEq("wr_data", mem_wdata, e.data);
          checkEq("wr_ben", mem_byteen, e.ben);
        end
      end
      holdValid = mem_req && !mem_ack;
      holdAddr  = mem_addr;
      holdData  = mem_wdata;
      holdBen   = mem_byteen;
    end
  end

  // Called at posedge+1; holds the store until accepted (bounded) and records it if it allocates.
  task automatic pushStore(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bit done = 1'b0;
    st_valid = 1'b1; st_addr = a; st_wdata = d; st_byteen = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (st_ready) begin
        done = 1'b1;
        if (b != 4'b0000) sbQ.push_back('{addr: {a[31:2], 2'b00}, data: d, ben: b});
      end
      @(posedge clk); #1;
    end
    st_valid = 1'b0;
    checkEq("push_accepted", done, 1);
  endtask

  task automatic waitDrain();
    bit idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = !mem_req;
    end
    checkEq("drain_done", mem_req, 0);
    checkEq("sb_empty", sbQ.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int popsLeft;
    bit prevLast;

    // Reset state.
    ld_valid = 1'b1; ld_addr = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rst_mem_req", mem_req, 0);
    checkEq("rst_st_ready", st_ready, 1);
    checkEq("rst_ld_hit", ld_hit, 0);
    checkEq("rst_flush_done", flush_done, 0);
    @(posedge clk); #1;
    reset = 1'b0; ld_valid = 1'b0;
    @(posedge clk); #1;

    // Single store with ack tied high.
    mem_ack = 1'b1;
    st_valid = 1'b1; st_addr = 32'h0000_0104; st_wdata = 32'h0000_AB00; st_byteen = 4'b0010;
    @(negedge clk);
    checkEq("single_ready", st_ready, 1);
    checkEq("single_no_same_cycle_req", mem_req, 0);
    sbQ.push_back('{addr: 32'h0000_0104, data: 32'h0000_AB00, ben: 4'b0010});
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(negedge clk);
    checkEq("single_req_lat1", mem_req, 1);
    @(negedge clk);
    checkEq("single_count_zero", mem_req, 0);
    @(posedge clk); #1;

    // Zero byte enable: accepted, nothing written.
    pushStore(32'h0000_0F00, 32'h1234_5678, 4'b0000);
    @(negedge clk);
    checkEq("zero_ben_no_req", mem_req, 0);
    @(posedge clk); #1;

    // Fill with backpressure; low address bits must be dropped on issue.
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pushStore(32'h0000_1000 + 32'(i * 5), $urandom, 4'(i + 1));
    end
    st_valid = 1'b1; st_addr = 32'h0000_1014; st_wdata = 32'h5555_AAAA; st_byteen = 4'b1100;
    @(negedge clk);
    checkEq("full_not_ready", st_ready, 0);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(negedge clk);
    checkEq("full_no_passthru", st_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkEq("ready_after_pop", st_ready, 1);
    sbQ.push_back('{addr: 32'h0000_1014, data: 32'h5555_AAAA, ben: 4'b1100});
    @(posedge clk); #1;
    st_valid = 1'b0;
    waitDrain();

    // Load hazard detection.
    mem_ack = 1'b0;
    pushStore(32'h0000_0200, 32'hCAFE_BABE, 4'b1111);
    ld_valid = 1'b1; ld_addr = 32'h0000_0203;
    @(negedge clk); checkEq("ld_hit_same_word", ld_hit, 1);
    @(posedge clk); #1; ld_addr = 32'h0000_0204;
    @(negedge clk); checkEq("ld_hit_next_word", ld_hit, 0);
    @(posedge clk); #1; ld_addr = 32'h0000_0200; ld_valid = 1'b0;
    @(negedge clk); checkEq("ld_hit_gated", ld_hit, 0);
    @(posedge clk); #1; ld_valid = 1'b1; mem_ack = 1'b1;
    @(negedge clk); checkEq("ld_hit_popping_head", ld_hit, 1);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk); checkEq("ld_hit_after_drain", ld_hit, 0);
    @(posedge clk); #1;
    ld_addr = 32'h0000_0500;
    st_valid = 1'b1; st_addr = 32'h0000_0500; st_wdata = 32'h0000_0077; st_byteen = 4'b0001;
    @(negedge clk);
    checkEq("ld_no_incoming_hit", ld_hit, 0);
    checkEq("ld_store_ready", st_ready, 1);
    sbQ.push_back('{addr: 32'h0000_0500, data: 32'h0000_0077, ben: 4'b0001});
    @(posedge clk); #1; st_valid = 1'b0;
    @(negedge clk); checkEq("ld_hit_next_cycle", ld_hit, 1);
    @(posedge clk); #1; ld_valid = 1'b0; mem_ack = 1'b1;
    waitDrain();

    // Flush while empty: done pulses two cycles after flush.
    mem_ack = 1'b0; flush = 1'b1;
    @(negedge clk); checkEq("fe_done_c0", flush_done, 0);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk); checkEq("fe_done_c1", flush_done, 0); checkEq("fe_ready_c1", st_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); checkEq("fe_done_c2", flush_done, 1);
    @(posedge clk); #1;
    @(negedge clk); checkEq("fe_done_c3", flush_done, 0); checkEq("fe_ready_c3", st_ready, 1);
    @(posedge clk); #1;

    // Flush with three entries and ack every other cycle.
    pushStore(32'h0000_0600, 32'h0000_0001, 4'b0001);
    pushStore(32'h0000_0604, 32'h0000_0200, 4'b0010);
    pushStore(32'h0000_0608, 32'h0003_0000, 4'b0100);
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    pulses = 0; popsLeft = 3; prevLast = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_ack = (i % 2 == 1);
      flush = (i < 3);
      @(negedge clk);
      if (flush_done) begin
        pulses++;
        checkEq("fl_done_after_last_pop", prevLast, 1);
      end else if (pulses == 0) begin
        checkEq("fl_ready_blocked", st_ready, 0);
      end
      prevLast = 1'b0;
      if (mem_req && mem_ack) begin
        popsLeft--;
        prevLast = (popsLeft == 0);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; flush = 1'b0;
    checkEq("fl_pulse_count", pulses, 1);
    checkEq("fl_sb_empty", sbQ.size(), 0);

    // Reset in the middle of a drain abandons everything.
    pushStore(32'h0000_0800, 32'hAAAA_0000, 4'b1111);
    pushStore(32'h0000_0804, 32'hBBBB_0000, 4'b1111);
    pushStore(32'h0000_0808, 32'hCCCC_0000, 4'b1111);
    @(negedge clk); checkEq("pre_reset_req", mem_req, 1);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 32'h0000_0800;
    reset = 1'b1;
    #1;
    checkEq("mid_rst_req", mem_req, 0);
    checkEq("mid_rst_ready", st_ready, 1);
    checkEq("mid_rst_ld_hit", ld_hit, 0);
    sbQ.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; ld_valid = 1'b0; mem_ack = 1'b1;
    repeat (8) @(negedge clk);
    checkEq("post_rst_no_req", mem_req, 0);
    @(posedge clk); #1;

`ifdef WBUF_MERGE_EN
    // Merge into the youngest entry while the head is stalled.
    mem_ack = 1'b0;
    pushStore(32'h0000_0300, 32'h0000_00AA, 4'b0001);
    pushStore(32'h0000_0400, 32'h0000_00BB, 4'b0001);
    st_valid = 1'b1; st_addr = 32'h0000_0400; st_wdata = 32'hCC00_0000; st_byteen = 4'b1000;
    @(negedge clk);
    checkEq("merge_ready", st_ready, 1);
    begin
      wrT t;
      t = sbQ[sbQ.size() - 1];
      t.ben = 4'b1001;
      t.data = 32'hCC00_00BB;
      sbQ[sbQ.size() - 1] = t;
    end
    @(posedge clk); #1; st_valid = 1'b0;
    mem_ack = 1'b1;
    waitDrain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
